// File: rtl/example_arbiter.sv
// Round-robin arbiter that shares one engine among N_REQ requesters: grant, hold
// start for hold+1 cycles, wait for done (with watchdog), return the result with ack.
module example_arbiter #(
  parameter int         N_REQ     = 4,
  parameter int         TIMEOUT   = 1023,
  parameter logic [2:0] IDLE_CODE = 3'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_offset,
  input  logic [8*N_REQ-1:0]   req_target,
  input  logic [4*N_REQ-1:0]   req_hold,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           rsp_data,
  output logic                 err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [1:0]           eng_offset,
  output logic [7:0]           eng_target,
  input  logic                 eng_done,
  input  logic [2:0]           eng_state,
  input  logic [7:0]           eng_variable
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_WAIT, S_RESP} state_t;

  state_t           state, state_n;
  idx_t             ptr, ptr_n;
  idx_t             winner, winner_n;
  logic [3:0]       hold, hold_n;
  logic [9:0]       wd, wd_n;
  logic [N_REQ-1:0] ack_n;
  logic [7:0]       rsp_n;
  logic             err_n;
  logic             start_n;
  logic [1:0]       offset_n;
  logic [7:0]       target_n;
  logic             busy_n;
  logic             found;
  int               scan_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_n  = state;
    ptr_n    = ptr;
    winner_n = winner;
    hold_n   = hold;
    wd_n     = wd;
    ack_n    = '0;
    rsp_n    = rsp_data;
    err_n    = err;
    start_n  = eng_start;
    offset_n = eng_offset;
    target_n = eng_target;
    found    = 1'b0;
    scan_idx = 0;

    unique case (state)
      S_IDLE: begin
        // An engine still busy after a controller-only reset must finish first.
        if (|req && (eng_state == IDLE_CODE)) begin
          for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[scan_idx]) begin
              found    = 1'b1;
              winner_n = idx_t'(scan_idx);
              offset_n = req_offset[2*scan_idx +: 2];
              target_n = req_target[8*scan_idx +: 8];
              hold_n   = req_hold[4*scan_idx +: 4];
            end
          end
          state_n = S_GRANT;
        end
      end

      S_GRANT: begin
        start_n = 1'b1;
        state_n = S_START;
      end

      S_START: begin
        if (hold != 4'd0) begin
          hold_n = hold - 4'd1;
        end else begin
          start_n = 1'b0;
          wd_n    = '0;
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (eng_done) begin
          rsp_n         = eng_variable;
          ack_n[winner] = 1'b1;
          state_n       = S_RESP;
        end else if (wd == WD_LAST) begin
          err_n   = 1'b1;
          state_n = S_RESP;
        end else begin
          wd_n = wd + 10'd1;
        end
      end

      S_RESP: begin
        ptr_n   = winner;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= idx_t'(N_REQ - 1);
      winner     <= '0;
      hold       <= '0;
      wd         <= '0;
      ack        <= '0;
      rsp_data   <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      eng_offset <= '0;
      eng_target <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values computed above, independent of statement order.
      state      <= state_n;
      ptr        <= ptr_n;
      winner     <= winner_n;
      hold       <= hold_n;
      wd         <= wd_n;
      ack        <= ack_n;
      rsp_data   <= rsp_n;
      err        <= err_n;
      busy       <= busy_n;
      eng_start  <= start_n;
      eng_offset <= offset_n;
      eng_target <= target_n;
    end
  end

endmodule

// File: tb/tb_example_arbiter.sv
// Self-checking bench for example_arbiter: behavioural engine stub plus a
// round-robin reference model built from the grant rules.
`timescale 1ns/1ps
module tb_example_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_offset;
  logic [8*N-1:0] req_target;
  logic [4*N-1:0] req_hold;
  logic [N-1:0]   ack;
  logic [7:0]     rsp_data;
  logic           err;
  logic           busy;
  logic           eng_start;
  logic [1:0]     eng_offset;
  logic [7:0]     eng_target;
  logic           eng_done;
  logic [2:0]     eng_state;
  logic [7:0]     eng_variable;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr;

  logic       hang   = 1'b0;
  logic       ovr_en = 1'b0;
  logic [2:0] ovr_val = 3'd0;
  int         phase, stub_cnt, stub_lat;
  logic [7:0] stub_var;

  always #5 clk = ~clk;

  assign eng_state = ovr_en ? ovr_val : 3'd0;

  example_arbiter #(.N_REQ(N), .TIMEOUT(TO), .IDLE_CODE(3'd0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_offset(req_offset), .req_target(req_target), .req_hold(req_hold),
    .ack(ack), .rsp_data(rsp_data), .err(err), .busy(busy),
    .eng_start(eng_start), .eng_offset(eng_offset), .eng_target(eng_target),
    .eng_done(eng_done), .eng_state(eng_state), .eng_variable(eng_variable)
  );

  // Engine stub: after start falls, pulse done for one cycle after a random delay
  // with a fresh random result; in hang mode it never completes.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase = 0; eng_done = 1'b0; eng_variable = 8'h00; stub_var = 8'h00;
      stub_cnt = 0; stub_lat = 0;
    end else begin
      eng_done = 1'b0;
      case (phase)
        0: if (eng_start === 1'b1) phase = 1;
        1: if (eng_start === 1'b0) begin
             phase = 2; stub_cnt = 0; stub_lat = $urandom_range(0, 10);
           end
        default: begin
          if (busy !== 1'b1) phase = 0;
          else if (!hang) begin
            if (stub_cnt == stub_lat) begin
              stub_var = 8'($urandom); eng_variable = stub_var; eng_done = 1'b1; phase = 0;
            end else stub_cnt++;
          end
        end
      endcase
    end
  end

  // Round-robin rule: first requesting index after the last winner, wrapping.
  function automatic int pick(input logic [N-1:0] m);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((model_ptr + k) % N);
    foreach (order[i]) if (m[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic randomize_payload();
    req_offset = (2*N)'($urandom);
    req_target = {$urandom, $urandom};
    req_hold   = (4*N)'($urandom);
  endtask

  // Follows one job for requester w from start to ack and checks every phase.
  task automatic serve_one(input int w, input bit drop);
    int t, len, exp_len;
    logic [N-1:0] exp_ack;
    t = 0;
    while (eng_start !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL start_timeout: eng_start=%b after %0d cycles, want 1", eng_start, t);
      return;
    end
    n_cmp++;
    if ({eng_offset, eng_target} !== {req_offset[2*w +: 2], req_target[8*w +: 8]}) begin
      n_bad++; $display("FAIL payload[%0d]: offset/target=%h/%h want %h/%h", w, eng_offset,
                        eng_target, req_offset[2*w +: 2], req_target[8*w +: 8]);
    end
    len = 0;
    exp_len = int'(req_hold[4*w +: 4]) + 1;
    while (eng_start === 1'b1 && len < 40) begin @(negedge clk); len++; end
    n_cmp++;
    if (len != exp_len) begin
      n_bad++; $display("FAIL start_len[%0d]: %0d cycles want %0d", w, len, exp_len);
    end
    t = 0;
    while (ack === '0 && t < 60) begin @(negedge clk); t++; end
    exp_ack = '0;
    exp_ack[w] = 1'b1;
    n_cmp++;
    if (ack !== exp_ack || rsp_data !== stub_var) begin
      n_bad++; $display("FAIL ack_rsp[%0d]: ack=%b rsp=%h want ack=%b rsp=%h", w, ack, rsp_data,
                        exp_ack, stub_var);
    end
    model_ptr = w;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ack_width[%0d]: ack=%b busy=%b want 0/0", w, ack, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; randomize_payload();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, rsp_data, err, busy, eng_start, eng_offset, eng_target} !== '0) begin
      n_bad++; $display("FAIL reset_state: ack=%b rsp=%h err=%b busy=%b start=%b off=%h tgt=%h want all 0",
                        ack, rsp_data, err, busy, eng_start, eng_offset, eng_target);
    end
    reset_n = 1'b1;
    model_ptr = N - 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || eng_start !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy=%b start=%b want 0/0", busy, eng_start);
    end
  endtask

  task automatic test_fairness();
    int w;
    randomize_payload();
    req = '1;
    for (int i = 0; i <= N; i++) begin
      w = pick(req);
      n_cmp++;
      if (w != (i % N)) begin
        n_bad++; $display("FAIL fair_order: model winner %0d want %0d", w, i % N);
      end
      serve_one(w, 1'b0);
      if (i < N) begin
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL fair_gap: busy=%b want 1 after single idle cycle", busy);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_single();
    randomize_payload();
    req_hold[3:0] = 4'd3; req_offset[1:0] = 2'd0;
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || eng_start !== 1'b0) begin
      n_bad++; $display("FAIL grant_lat1: busy=%b start=%b want 1/0", busy, eng_start);
    end
    @(negedge clk);
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL grant_lat2: start=%b want 1", eng_start);
    end
    serve_one(pick(req), 1'b1);
    req_hold[11:8] = 4'd0; req_offset[5:4] = 2'd1;
    req = 4'b0100;
    serve_one(pick(req), 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    for (int r = 0; r < 8; r++) begin
      randomize_payload();
      m = N'($urandom_range(1, (1 << N) - 1));
      req = m;
      serve_one(pick(m), 1'b1);
      req = '0;
    end
  endtask

  task automatic test_not_idle();
    int bad;
    randomize_payload();
    ovr_en = 1'b1; ovr_val = 3'd2;
    req = 4'b0010;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (eng_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL not_idle: %0d cycles with start/busy high, want 0", bad);
    end
    ovr_en = 1'b0;
    serve_one(pick(req), 1'b1);
  endtask

  task automatic test_watchdog();
    int k, t, w;
    bit saw_ack;
    randomize_payload();
    hang = 1'b1;
    req = 4'b1000;
    w = pick(req);
    t = 0;
    while (eng_start !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    while (eng_start === 1'b1 && t < 100) begin @(negedge clk); t++; end
    k = 0; saw_ack = 1'b0;
    while (err !== 1'b1 && k < 40) begin
      if (ack !== '0) saw_ack = 1'b1;
      @(negedge clk); k++;
    end
    n_cmp++;
    if (k != TO || saw_ack) begin
      n_bad++; $display("FAIL watchdog: err after %0d cycles ack_seen=%b want %0d/0", k, saw_ack, TO);
    end
    model_ptr = w;
    req = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL watchdog_noack: ack=%b busy=%b want 0/0", ack, busy);
    end
    hang = 1'b0;
    randomize_payload();
    req = N'($urandom_range(1, (1 << N) - 1));
    serve_one(pick(req), 1'b1);
    req = '0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_reset_mid_start();
    int t;
    randomize_payload();
    req_hold[15:12] = 4'd12;
    req = 4'b1000;
    t = 0;
    while (eng_start !== 1'b1 && t < 60) begin @(negedge clk); t++; end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (eng_start !== 1'b0 || busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: start=%b busy=%b ack=%b err=%b want 0/0/0/0",
                        eng_start, busy, ack, err);
    end
    model_ptr = N - 1;
    req = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if (pick(req) != 0) begin
      n_bad++; $display("FAIL reset_prio_model: model winner %0d want 0", pick(req));
    end
    serve_one(pick(req), 1'b1);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_random();
    test_not_idle();
    test_watchdog();
    test_reset_mid_start();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
